// File: rtl/fifo_nibble_pkg.sv
// Shared constants and state encoding for the nibble-to-word assembler.
package fifo_nibble_pkg;

  localparam int unsigned NIBBLE_WIDTH = 4;

  typedef enum logic {
    COLLECT,
    HOLD
  } assembler_state_t;

endpackage

// File: rtl/fifo_nibble_assembler.sv
// Pops nibbles from a FWFT FIFO and packs them MSB-first into a word presented
// on a valid/ready handshake; flush emits a zero-padded partial word.
module fifo_nibble_assembler
  import fifo_nibble_pkg::*;
#(
  parameter int unsigned NIBBLES_PER_WORD = 4
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     fifo_empty_i,
  input  logic [NIBBLE_WIDTH-1:0]                  fifo_data_i,
  output logic                                     fifo_read_o,
  input  logic                                     flush_i,
  output logic [NIBBLE_WIDTH*NIBBLES_PER_WORD-1:0] word_o,
  output logic                                     word_valid_o,
  output logic                                     word_partial_o,
  input  logic                                     word_ready_i
);

  localparam int unsigned W    = NIBBLE_WIDTH * NIBBLES_PER_WORD;
  localparam int unsigned CntW = $clog2(NIBBLES_PER_WORD + 1);

  assembler_state_t state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [W-1:0]     word_q, word_d;
  logic             valid_q, valid_d;
  logic             partial_q, partial_d;

  logic [W-1:0]     shifted;
  logic [31:0]      pad_bits;

  // Gated by reset so no pop can reach the FIFO while the block is held in reset.
  assign fifo_read_o = reset_i & (state_q == COLLECT) & ~fifo_empty_i & ~flush_i;

  assign shifted  = {acc_q[W-NIBBLE_WIDTH-1:0], fifo_data_i};
  assign pad_bits = NIBBLE_WIDTH * (NIBBLES_PER_WORD - 32'(count_q));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    word_d    = word_q;
    valid_d   = valid_q;
    partial_d = partial_q;

    unique case (state_q)
      COLLECT: begin
        if (flush_i) begin
          if (count_q != '0) begin
            // Left-align the collected nibbles so the unfilled tail reads as zero.
            word_d    = acc_q << pad_bits;
            valid_d   = 1'b1;
            partial_d = 1'b1;
            count_d   = '0;
            acc_d     = '0;
            state_d   = HOLD;
          end
        end else if (fifo_read_o) begin
          if (count_q == CntW'(NIBBLES_PER_WORD - 1)) begin
            word_d    = shifted;
            valid_d   = 1'b1;
            partial_d = 1'b0;
            count_d   = '0;
            acc_d     = '0;
            state_d   = HOLD;
          end else begin
            acc_d   = shifted;
            count_d = count_q + CntW'(1);
          end
        end
      end
      HOLD: begin
        if (valid_q && word_ready_i) begin
          valid_d = 1'b0;
          state_d = COLLECT;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= COLLECT;
      acc_q     <= '0;
      count_q   <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      partial_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      partial_q <= partial_d;
    end
  end

  assign word_o         = word_q;
  assign word_valid_o   = valid_q;
  assign word_partial_o = partial_q;

endmodule
